cam_pixel_capture: RTL and testbench
====================================

Name: cam_pixel_capture

Overview:
Camera-side capture stage that sits directly upstream of the pixel FIFO. It samples the OV7670-style byte stream (vsync, href, 8-bit data), pairs bytes into RGB565 pixels, and issues single-cycle write strobes into the FIFO. It also tracks pixel and line position, and flags overflow and line-length errors per frame.

Parameters:
H_PIXELS, 320, pixels per active line that are accepted; extra pixels are dropped.
V_LINES, 240, lines per frame that are accepted; extra lines are dropped.
XW, 10, width of the pixel counter; must satisfy 2**XW > H_PIXELS.
YW, 9, width of the line counter; must satisfy 2**YW > V_LINES.

Ports:
clock  in  1  pixel clock; all logic on posedge.
reset  in  1  asynchronous, active-high.
enable  in  1  capture enable; sampled only at frame boundaries.
vsync  in  1  camera frame sync; high during vertical blank.
href  in  1  camera line valid; high during active bytes.
d_in  in  8  camera data byte.
fifo_full  in  1  FIFO full flag; a write is blocked while it is high.
pix_out  out  16  assembled pixel {first byte, second byte}.
pix_wr  out  1  one-cycle write strobe to the FIFO.
x_cnt  out  XW  pixels emitted on the current line.
y_cnt  out  YW  completed lines in the current frame.
frame_done  out  1  one-cycle pulse at end of frame.
overflow  out  1  sticky: at least one pixel was lost to fifo_full this frame.
len_err  out  1  sticky: a line was not exactly H_PIXELS long this frame.
busy  out  1  high in state ACTIVE.

Behaviour:
- Reset is asynchronous, active-high, on clock clock. All outputs and state go to 0, FSM goes to IDLE, byte phase goes to 0.
- Input stage: vsync, href and d_in are registered once (vs_q, hr_q, d_q). All decisions use the registered copies plus a one-cycle-delayed copy for edge detection.
- FSM states are IDLE, SYNC, ACTIVE.
  - IDLE: leave to SYNC when enable=1.
  - SYNC: wait for a vsync falling edge (vs_q=0 while its delayed copy=1). On that edge: go to ACTIVE; clear x_cnt, y_cnt, phase, overflow and len_err.
  - ACTIVE, vsync rising edge: pulse frame_done for one cycle. Go to SYNC if enable=1, otherwise to IDLE.
- Enable deasserted mid-frame: the current frame completes; there is no abort.
- Byte pairing, in ACTIVE with hr_q=1:
  - phase 0: store d_q as the high byte; phase becomes 1.
  - phase 1: form pixel {hi, d_q}; phase becomes 0.
- Pixel emit: on the cycle after phase 1, pix_out is registered and pix_wr=1 if all of the following hold: fifo_full=0, x_cnt<H_PIXELS, y_cnt<V_LINES.
- Latency: 2 clocks from the second byte at the pins to pix_wr high.
- pix_out holds its value when pix_wr=0.
- x_cnt increments on every formed pixel while x_cnt<H_PIXELS, including pixels dropped for fifo_full. It saturates at H_PIXELS.
- A formed pixel dropped because fifo_full=1 sets overflow. Pixels dropped only because they exceed H_PIXELS or V_LINES do not set overflow.
- href falling edge (hr_q=0 while its delayed copy=1) in ACTIVE:
  - If the line held any pixels or bytes: y_cnt increments, saturating at V_LINES.
  - If pixel count ≠ H_PIXELS, or phase=1 (odd byte count): set len_err.
  - Clear x_cnt and phase. A dangling odd byte is discarded.
- Simultaneous vsync rising and href falling edges: the line is closed first (y_cnt and len_err updated), then frame_done pulses in the same cycle.
- href activity in IDLE or SYNC is ignored; nothing is written.
- Reset mid-line: the partial pixel is lost and no strobe is issued.
- Counters never wrap: x_cnt saturates at H_PIXELS and y_cnt at V_LINES.

Test Plan:
Bench parameters: H_PIXELS=4, V_LINES=2.
1. Reset, enable=1, vsync 1→0, two lines of 8 bytes 0x11..0x18, then vsync↑ -> pix_wr pulses 8 times; the first pix_out is 0x1112, the last 0x1718; y_cnt=2; frame_done pulses once; overflow=0; len_err=0.
2. fifo_full=1 held during the 2nd pixel of line 0 -> 7 writes; pixel 0x1314 is absent; overflow=1; x_cnt reaches 4 on that line.
3. Line of 10 bytes (5 pixels), then a line of 7 bytes -> 4 writes on the first line plus 3 on the second; len_err=1; the odd last byte is discarded.
4. Three lines of 8 bytes -> only 8 writes; y_cnt=2 (saturated); len_err=0.
5. href pulses before the vsync falling edge, and enable dropped mid-frame -> no writes before the falling edge; the frame completes; FSM goes to IDLE after vsync↑; the next frame produces no writes.
6. Assert reset after the first byte of a pixel, release, then run a normal frame -> no stray strobe; the first pixel of the new frame is correct and phase starts at 0.

Source files
------------

// File: rtl/cam_pixel_capture_if.sv
// Write port from the capture stage into the pixel FIFO.
// The capture stage is the master: it drives the pixel word and the
// single-cycle strobe, and it observes the FIFO full flag.
interface cam_pixel_capture_if;
    logic [15:0] pix_out;
    logic        pix_wr;
    logic        fifo_full;

    modport master (output pix_out, output pix_wr, input fifo_full);
    modport slave  (input pix_out, input pix_wr, output fifo_full);
endinterface

// File: rtl/cam_pixel_capture.sv
// Camera capture stage: samples an OV7670-style byte stream, pairs the
// bytes into RGB565 pixels and strobes them into the pixel FIFO.
// It also tracks the pixel/line position and raises sticky per-frame flags
// for FIFO overflow and wrong line length.
module cam_pixel_capture #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       vsync,
    input  logic                       href,
    input  logic [7:0]                 d_in,
    cam_pixel_capture_if.master        fifo,
    output logic [XW-1:0]              x_cnt,
    output logic [YW-1:0]              y_cnt,
    output logic                       frame_done,
    output logic                       overflow,
    output logic                       len_err,
    output logic                       busy
);

    localparam logic [XW-1:0] H_MAX = XW'(H_PIXELS);
    localparam logic [YW-1:0] V_MAX = YW'(V_LINES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Line counter increment that stops at V_LINES instead of wrapping.
    function automatic logic [YW-1:0] y_sat_inc(input logic [YW-1:0] y);
        return (y < V_MAX) ? (y + YW'(1)) : y;
    endfunction

    // Registered copies of the camera pins and their one-cycle delayed copies.
    logic       vs_q_r;
    logic       hr_q_r;
    logic [7:0] d_q_r;
    logic       vs_d_r;
    logic       hr_d_r;

    // Edge detectors, all derived from registered copies only.
    logic vs_fall_s;
    logic vs_rise_s;
    logic hr_fall_s;

    state_t         state_r;
    logic           phase_r;      // 0: next byte is the high byte
    logic [7:0]     hi_r;         // first byte of the pixel being assembled
    logic           line_act_r;   // at least one byte seen on this line
    logic           line_long_r;  // more than H_PIXELS pixels formed on this line
    logic [15:0]    pix_out_r;
    logic           pix_wr_r;
    logic [XW-1:0]  x_cnt_r;
    logic [YW-1:0]  y_cnt_r;
    logic           frame_done_r;
    logic           overflow_r;
    logic           len_err_r;
    logic           busy_r;

    assign vs_fall_s = ~vs_q_r &  vs_d_r;
    assign vs_rise_s =  vs_q_r & ~vs_d_r;
    assign hr_fall_s = ~hr_q_r &  hr_d_r;

    // Input stage: register the pins once, then keep a delayed copy for edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vs_q_r <= 1'b0;
            hr_q_r <= 1'b0;
            d_q_r  <= 8'h00;
            vs_d_r <= 1'b0;
            hr_d_r <= 1'b0;
        end else begin
            vs_q_r <= vsync;
            hr_q_r <= href;
            d_q_r  <= d_in;
            vs_d_r <= vs_q_r;
            hr_d_r <= hr_q_r;
        end
    end

    // Frame FSM, byte pairing, pixel emit, position counters and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            phase_r      <= 1'b0;
            hi_r         <= 8'h00;
            line_act_r   <= 1'b0;
            line_long_r  <= 1'b0;
            pix_out_r    <= 16'h0000;
            pix_wr_r     <= 1'b0;
            x_cnt_r      <= {XW{1'b0}};
            y_cnt_r      <= {YW{1'b0}};
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
            len_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            pix_wr_r     <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        state_r <= SYNC;
                    end
                end
                SYNC: begin
                    if (vs_fall_s) begin
                        state_r     <= ACTIVE;
                        busy_r      <= 1'b1;
                        x_cnt_r     <= {XW{1'b0}};
                        y_cnt_r     <= {YW{1'b0}};
                        phase_r     <= 1'b0;
                        overflow_r  <= 1'b0;
                        len_err_r   <= 1'b0;
                        line_act_r  <= 1'b0;
                        line_long_r <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (hr_fall_s) begin
                        // Close the line; a dangling odd byte is simply dropped.
                        if (line_act_r) begin
                            y_cnt_r <= y_sat_inc(y_cnt_r);
                        end
                        if (line_long_r || (x_cnt_r != H_MAX) || phase_r) begin
                            len_err_r <= 1'b1;
                        end
                        x_cnt_r     <= {XW{1'b0}};
                        phase_r     <= 1'b0;
                        line_act_r  <= 1'b0;
                        line_long_r <= 1'b0;
                    end else if (hr_q_r) begin
                        line_act_r <= 1'b1;
                        if (!phase_r) begin
                            hi_r    <= d_q_r;
                            phase_r <= 1'b1;
                        end else begin
                            phase_r <= 1'b0;
                            if (x_cnt_r < H_MAX) begin
                                // Pixel position advances even if the FIFO refuses it.
                                x_cnt_r <= x_cnt_r + XW'(1);
                                if (y_cnt_r < V_MAX) begin
                                    if (fifo.fifo_full) begin
                                        overflow_r <= 1'b1;
                                    end else begin
                                        pix_out_r <= {hi_r, d_q_r};
                                        pix_wr_r  <= 1'b1;
                                    end
                                end
                            end else begin
                                line_long_r <= 1'b1;
                            end
                        end
                    end
                    // Line close above lands in the same cycle as frame_done.
                    if (vs_rise_s) begin
                        frame_done_r <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= enable ? SYNC : IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.pix_out = pix_out_r;
    assign fifo.pix_wr  = pix_wr_r;
    assign x_cnt        = x_cnt_r;
    assign y_cnt        = y_cnt_r;
    assign frame_done   = frame_done_r;
    assign overflow     = overflow_r;
    assign len_err      = len_err_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Self-checking bench for cam_pixel_capture with H_PIXELS=4, V_LINES=2.
// Frames are described as lists of lines (bytes plus a per-slot FIFO-full
// pattern); a line-level reference model derives the expected writes and flags.
module tb_cam_pixel_capture;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int XW = 3;
    localparam int YW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          vsync;
    logic          href;
    logic [7:0]    d_in;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          frame_done;
    logic          overflow;
    logic          len_err;
    logic          busy;

    cam_pixel_capture_if fif ();

    cam_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .XW(XW), .YW(YW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .vsync(vsync),
        .href(href), .d_in(d_in), .fifo(fif), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .frame_done(frame_done), .overflow(overflow), .len_err(len_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Count one comparison and report it if it mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Observed activity, sampled on the falling edge.
    logic [15:0] got_q[$];
    int fd_cnt;
    int fd_y;
    int max_x;

    // Collect writes, frame_done pulses and the largest x position seen.
    always @(negedge clock) begin
        if (fif.pix_wr === 1'b1) got_q.push_back(fif.pix_out);
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_y = int'(y_cnt);
        end
        if (int'(x_cnt) > max_x) max_x = int'(x_cnt);
    end

    // Frame description.
    int         nl;
    int         len[4];
    logic [7:0] dat[4][12];
    bit         full[4][12];
    bit         simul;
    bit         pre_pulse;
    bit         frame_en;
    int         en_drop_line;

    // Reference expectations.
    logic [15:0] exp_q[$];
    int exp_y, exp_ovf, exp_lerr, exp_maxx;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic clear_cfg();
        nl = 0; simul = 0; pre_pulse = 0; frame_en = 1; en_drop_line = -1;
        for (int l = 0; l < 4; l++) begin
            len[l] = 0;
            for (int i = 0; i < 12; i++) begin
                dat[l][i]  = 8'h00;
                full[l][i] = 1'b0;
            end
        end
    endtask

    task automatic std_lines(input int n);
        nl = n;
        for (int l = 0; l < n; l++) begin
            len[l] = 8;
            for (int i = 0; i < 8; i++) dat[l][i] = 8'(8'h11 + i);
        end
    endtask

    // Line-level model: pixel j of a line is bytes 2j,2j+1 and is refused when
    // the FIFO is full in the slot where byte 2j+2 would be presented.
    task automatic build_model();
        int npix;
        exp_q.delete();
        exp_y = 0; exp_ovf = 0; exp_lerr = 0; exp_maxx = 0;
        for (int l = 0; l < nl; l++) begin
            npix = len[l] / 2;
            for (int j = 0; j < npix; j++) begin
                if (j < H && exp_y < V) begin
                    if (full[l][2*j+2]) exp_ovf = 1;
                    else exp_q.push_back({dat[l][2*j], dat[l][2*j+1]});
                end
            end
            if (((npix < H) ? npix : H) > exp_maxx) exp_maxx = (npix < H) ? npix : H;
            if (len[l] > 0 && exp_y < V) exp_y++;
            if (npix != H || (len[l] % 2) != 0) exp_lerr = 1;
        end
    endtask

    // Drive one frame: blank, vsync fall, lines with gaps, vsync rise.
    task automatic drive_frame();
        enable = frame_en;
        vsync = 1'b1; href = 1'b0; fif.fifo_full = 1'b0;
        for (int k = 0; k < 3; k++) step();
        if (pre_pulse) begin
            for (int k = 0; k < 6; k++) begin
                href = (k < 3);
                d_in = 8'($urandom);
                step();
            end
            href = 1'b0;
            for (int k = 0; k < 3; k++) step();
        end
        vsync = 1'b0;
        for (int k = 0; k < 3; k++) step();
        for (int l = 0; l < nl; l++) begin
            if (l == en_drop_line) enable = 1'b0;
            for (int i = 0; i < len[l]; i++) begin
                href = 1'b1; d_in = dat[l][i]; fif.fifo_full = full[l][i];
                step();
            end
            href = 1'b0; d_in = 8'h00; fif.fifo_full = full[l][len[l]];
            if (simul && l == nl - 1) vsync = 1'b1;
            step();
            fif.fifo_full = 1'b0;
            step();
            step();
        end
        vsync = 1'b1;
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic run_frame(input string name);
        int n;
        got_q.delete(); fd_cnt = 0; fd_y = -1; max_x = 0;
        drive_frame();
        if (frame_en) build_model();
        else exp_q.delete();
        check_val({name, "/writes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_val($sformatf("%s/pix%0d", name, i), got_q[i], exp_q[i]);
        check_val({name, "/busy"}, busy, 0);
        if (frame_en) begin
            check_val({name, "/frame_done"}, fd_cnt, 1);
            check_val({name, "/y_at_done"}, fd_y, exp_y);
            check_val({name, "/y_cnt"}, y_cnt, exp_y);
            check_val({name, "/overflow"}, overflow, exp_ovf);
            check_val({name, "/len_err"}, len_err, exp_lerr);
            check_val({name, "/max_x"}, max_x, exp_maxx);
        end else begin
            check_val({name, "/frame_done"}, fd_cnt, 0);
        end
    endtask

    task automatic check_reset_state(input string name);
        check_val({name, "/pix_wr"}, fif.pix_wr, 0);
        check_val({name, "/pix_out"}, fif.pix_out, 0);
        check_val({name, "/x_cnt"}, x_cnt, 0);
        check_val({name, "/y_cnt"}, y_cnt, 0);
        check_val({name, "/frame_done"}, frame_done, 0);
        check_val({name, "/overflow"}, overflow, 0);
        check_val({name, "/len_err"}, len_err, 0);
        check_val({name, "/busy"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0;
        d_in = 8'h00; fif.fifo_full = 1'b0;
        step(); step();
        check_reset_state("rst0");
        reset = 1'b0;
        step();

        // 1: two clean lines
        clear_cfg(); std_lines(2);
        run_frame("basic");
        if (got_q.size() == 8) begin
            check_val("basic/first", got_q[0], 16'h1112);
            check_val("basic/last",  got_q[7], 16'h1718);
        end else begin
            check_val("basic/count8", got_q.size(), 8);
        end

        // 2: FIFO full while the second pixel of line 0 is emitted
        clear_cfg(); std_lines(2); full[0][4] = 1'b1;
        run_frame("full");

        // 3: long line then odd short line
        clear_cfg(); nl = 2; len[0] = 10; len[1] = 7;
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 12; i++) dat[l][i] = 8'($urandom);
        run_frame("len");

        // 4: one line too many, vsync rising together with the last href fall
        clear_cfg(); std_lines(3); simul = 1'b1;
        run_frame("vsat");

        // 5: href before vsync fall, enable dropped mid-frame, then a dead frame
        clear_cfg(); std_lines(2); pre_pulse = 1'b1; en_drop_line = 1;
        run_frame("endrop");
        clear_cfg(); std_lines(2); frame_en = 1'b0;
        run_frame("idle");

        // 6: reset after the first byte of a pixel
        clear_cfg();
        enable = 1'b1; vsync = 1'b1;
        for (int k = 0; k < 3; k++) step();
        vsync = 1'b0;
        for (int k = 0; k < 3; k++) step();
        href = 1'b1; d_in = 8'hA5; step();
        d_in = 8'h5A; reset = 1'b1; step();
        href = 1'b0; check_reset_state("rst1"); step();
        got_q.delete();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_val("rst1/stray", got_q.size(), 0);
        std_lines(2);
        run_frame("postrst");

        // Random frames
        for (int f = 0; f < 8; f++) begin
            clear_cfg();
            nl = int'($urandom_range(3, 1));
            simul = bit'($urandom_range(1, 0));
            for (int l = 0; l < nl; l++) begin
                len[l] = int'($urandom_range(11, 5));
                for (int i = 0; i < 12; i++) begin
                    dat[l][i]  = 8'($urandom);
                    full[l][i] = ($urandom_range(3, 0) == 0);
                end
            end
            run_frame($sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
